serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction; sampled only when ready=1.
REQ-005 SHALL have port a, input, N, minuend; sampled at the accepted start edge.
REQ-006 SHALL have port b, input, N, subtrahend; sampled at the accepted start edge.
REQ-007 SHALL have port bin, input, 1, borrow-in; sampled at the accepted start edge.
REQ-008 SHALL have port ready, output, 1, high only in state IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking a valid new result.
REQ-010 SHALL have port d, output, N, difference a - b - bin modulo 2^N.
REQ-011 SHALL have port bout, output, 1, unsigned borrow-out (1 when a < b + bin).
REQ-012 SHALL have port ovf, output, 1, two's-complement signed overflow flag.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE with start=1 at an edge: latch a, b, bin into internal operand and borrow registers, clear bit counter, go to SHIFT.
REQ-015 IDLE with start=0: remain in IDLE.
REQ-016 SHIFT: one bit per clock, LSB first, using the operand LSBs and the running borrow: diff = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-017 SHIFT: shift operand registers right by one; shift diff bit into the MSB of a partial-result register; increment counter.
REQ-018 At the Nth SHIFT edge: load d with the completed partial result, bout with the final borrow, ovf = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]) using latched operand MSBs; go to DONE.
REQ-019 DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
REQ-020 Latency: done is high in the cycle that begins N+1 edges after the start-accept edge; ready is high again one edge later.
REQ-021 start while ready=0 (SHIFT or DONE) SHALL be ignored with no effect on state or operands.
REQ-022 d, bout, ovf SHALL hold their values from REQ-018 until the next completion; a, b, bin changes after acceptance SHALL have no effect.
REQ-023 Back-to-back operation: start held high continuously SHALL yield one accepted operation every N+2 cycles.
REQ-024 The counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-025 reset=1 SHALL immediately, without a clock edge, force: state IDLE, counter 0, operand/partial registers 0, d=0, bout=0, ovf=0, done=0, ready=1.
REQ-026 reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow and outputs SHALL read 0.
REQ-027 After reset deassertion the first start accepted SHALL behave exactly as REQ-014.

Structure
REQ-028 A shared package serial_sub_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and default width constant N_DEFAULT=4.
REQ-029 The one-bit difference/borrow logic of REQ-016 SHALL be a sub-module fullsub_cell (ports a, b, bin, d, bout), instantiated once.

Verification
REQ-030 a=0101, b=0011, bin=0, start -> done after N+1 edges, d=0010, bout=0, ovf=0.
REQ-031 a=0011, b=0101, bin=0 -> d=1110, bout=1, ovf=0.
REQ-032 a=1000, b=0001, bin=0 -> d=0111, bout=0, ovf=1; then a=0111, b=1111, bin=0 -> d=1000, bout=1, ovf=1.
REQ-033 a=0000, b=0000, bin=1 -> d=1111, bout=1, ovf=0; start pulsed again during SHIFT with different operands -> ignored, single done, result unchanged.
REQ-034 Start a=0101, b=0011; assert reset after 2 SHIFT edges -> ready=1, d=0, no done pulse; new operation after release gives correct result.
REQ-035 start held high across 3 operations -> done pulses exactly N+2 cycles apart, each result correct.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fullsub_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module fullsub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single fullsub_cell.
// state | meaning
// IDLE  | ready for a new operation
// SHIFT | one difference bit per clock, N clocks
// DONE  | result valid, one-cycle done pulse
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf
);

    localparam int CW = $clog2(N + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic           br_q, br_d;
    logic [N-2:0]   p_q, p_d;
    logic           amsb_q, amsb_d, bmsb_q, bmsb_d;
    logic [N-1:0]   d_q, d_d;
    logic           bout_q, bout_d, ovf_q, ovf_d;

    logic           cell_d, cell_bout;
    logic [N-1:0]   p_full;

    fullsub_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // The newest bit enters at the MSB; after N shifts p_full holds the whole difference.
    assign p_full = {cell_d, p_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        p_d     = p_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    amsb_d  = a[N-1];
                    bmsb_d  = b[N-1];
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = cell_bout;
                p_d   = p_full[N-1:1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    d_d     = p_full;
                    bout_d  = cell_bout;
                    ovf_d   = (amsb_q != bmsb_q) && (cell_d != amsb_q);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            p_q     <= '0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            p_q     <= p_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign d     = d_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: accepted operations push an arithmetic reference result, a monitor checks each done.
module tb_serial_subtractor;

    localparam int N = 4;
    localparam int M = 1 << N;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         bin = 1'b0;
    logic         ready, done, bout, ovf;
    logic [N-1:0] d;

    typedef struct packed {
        logic [N-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   done_t[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(int av, int bv, int bi);
        exp_t e;
        int   diff;
        diff   = (av - bv - bi + 2 * M) % M;
        e.d    = N'(diff);
        e.bout = (av < bv + bi);
        e.ovf  = ((av >= M / 2) != (bv >= M / 2)) && ((diff >= M / 2) != (av >= M / 2));
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset && ready && start) begin
            exp_q.push_back(model(int'(a), int'(b), int'(bin)));
            acc_q.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   at;
        if (prev_done) chk("ready_after_done", int'(ready), 1);
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e  = exp_q.pop_front();
                at = acc_q.pop_front();
                chk("d", int'(d), int'(e.d));
                chk("bout", int'(bout), int'(e.bout));
                chk("ovf", int'(ovf), int'(e.ovf));
                chk("latency", cyc - at, N);
                chk("ready_in_done", int'(ready), 0);
            end
            done_t.push_back(cyc);
        end
        prev_done = done;
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic run_op(logic [N-1:0] av, logic [N-1:0] bv, logic bi, bit poke);
        wait_ready();
        a = av; b = bv; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
        if (poke) begin
            @(negedge clk);
            start = 1'b1;
            a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        wait_ready();
    endtask

    initial begin
        int nd;
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_bout", int'(bout), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op(4'b0101, 4'b0011, 1'b0, 1'b0);
        chk("r030_d", int'(d), 4'b0010);
        chk("r030_bout", int'(bout), 0);
        run_op(4'b0011, 4'b0101, 1'b0, 1'b0);
        chk("r031_d", int'(d), 4'b1110);
        chk("r031_bout", int'(bout), 1);
        run_op(4'b1000, 4'b0001, 1'b0, 1'b0);
        chk("r032a_ovf", int'(ovf), 1);
        run_op(4'b0111, 4'b1111, 1'b0, 1'b0);
        chk("r032b_d", int'(d), 4'b1000);
        chk("r032b_ovf", int'(ovf), 1);

        nd = done_t.size();
        run_op(4'b0000, 4'b0000, 1'b1, 1'b1);
        chk("r033_done_count", done_t.size() - nd, 1);
        chk("r033_d", int'(d), 4'b1111);
        chk("r033_bout", int'(bout), 1);

        // Abort an operation two shift edges in.
        wait_ready();
        a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("abort_ready", int'(ready), 1);
        chk("abort_done", int'(done), 0);
        chk("abort_d", int'(d), 0);
        chk("abort_bout", int'(bout), 0);
        chk("abort_ovf", int'(ovf), 0);
        nd = done_t.size();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (N + 3) @(negedge clk);
        chk("abort_no_done", done_t.size() - nd, 0);
        chk("abort_d_held", int'(d), 0);
        run_op(4'b0101, 4'b0011, 1'b0, 1'b0);
        chk("after_reset_d", int'(d), 4'b0010);

        // start held high: one accept every N+2 cycles.
        wait_ready();
        nd = done_t.size();
        start = 1'b1;
        for (int i = 0; i < 3 * (N + 2); i++) begin
            a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_ready();
        chk("b2b_done_count", done_t.size() - nd, 3);
        if (done_t.size() - nd == 3) begin
            chk("b2b_spacing1", done_t[nd + 1] - done_t[nd], N + 2);
            chk("b2b_spacing2", done_t[nd + 2] - done_t[nd + 1], N + 2);
        end

        for (int i = 0; i < 40; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
